// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the 8-digit 7-segment display controller.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned VAL_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [7:0] HEX_OFF = 8'hFF;
  localparam logic [7:0] HEX_ALL = 8'h00;

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_BLANK = 2'b01,
    OP_BLINK = 2'b10,
    OP_DP    = 2'b11
  } op_e;

  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic             blank;
    logic             blink;
    logic             dp;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{val: '0, blank: 1'b1, blink: 1'b0, dp: 1'b0};

  function automatic digit_t apply_cmd(digit_t cur, op_e op, logic [VAL_W-1:0] data);
    digit_t nxt;
    nxt = cur;
    case (op)
      OP_SET:   begin nxt.val = data; nxt.blank = 1'b0; nxt.blink = 1'b0; end
      OP_BLANK: begin nxt.blank = 1'b1; nxt.blink = 1'b0; end
      OP_BLINK: begin nxt.val = data; nxt.blank = 1'b0; nxt.blink = 1'b1; end
      OP_DP:    nxt.dp = data[0];
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex value to active-low g..a segment pattern.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [VAL_W-1:0] val_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = '1;
    case (val_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = '1;
    endcase
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Two-requester round-robin digit controller with blink timer, lamp test
// and registered active-low HEX0..HEX7 outputs.
module hex_disp_ctrl
  import hex_disp_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 250,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       CLK_500Hz,
  input  logic       RESET_N,
  input  logic       req_a_valid,
  output logic       req_a_ready,
  input  logic [2:0] req_a_digit,
  input  logic [1:0] req_a_op,
  input  logic [3:0] req_a_data,
  input  logic       req_b_valid,
  output logic       req_b_ready,
  input  logic [2:0] req_b_digit,
  input  logic [1:0] req_b_op,
  input  logic [3:0] req_b_data,
  input  logic       lamp_test,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [7:0] HEX6,
  output logic [7:0] HEX7
);

  typedef enum logic {LAST_A, LAST_B} rr_e;

  rr_e                         last_q, last_d;
  digit_t [NUM_DIGITS-1:0]     dig_q, dig_d;
  logic   [CNT_W-1:0]          cnt_q, cnt_d;
  logic                        phase_q, phase_d;
  logic                        wrap;
  logic   [7:0]                hex_q [NUM_DIGITS];
  logic   [7:0]                hex_d [NUM_DIGITS];
  logic   [SEG_W-1:0]          seg   [NUM_DIGITS];
  logic                        grant_a, grant_b;

  // Grants are gated by reset so ready never rises during a reset cycle.
  always_comb begin
    grant_a = RESET_N && req_a_valid && (!req_b_valid || last_q == LAST_B);
    grant_b = RESET_N && req_b_valid && (!req_a_valid || last_q == LAST_A);
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decode u_dec (
      .val_i (dig_q[g].val),
      .seg_o (seg[g])
    );
  end

  always_comb begin
    dig_d  = dig_q;
    last_d = last_q;
    if (grant_a) begin
      dig_d[req_a_digit] = apply_cmd(dig_q[req_a_digit], op_e'(req_a_op), req_a_data);
      last_d = LAST_A;
    end else if (grant_b) begin
      dig_d[req_b_digit] = apply_cmd(dig_q[req_b_digit], op_e'(req_b_op), req_b_data);
      last_d = LAST_B;
    end
  end

  always_comb begin
    wrap    = (cnt_q == CNT_W'(BLINK_DIV - 1));
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    phase_d = phase_q ^ wrap;
  end

  // Outputs derive from current (pre-edge) state, giving one edge of latency.
  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hex_d[i] = HEX_OFF;
      if (lamp_test) begin
        hex_d[i] = HEX_ALL;
      end else begin
        hex_d[i][7]   = ~dig_q[i].dp;
        hex_d[i][6:0] = (dig_q[i].blank || (dig_q[i].blink && phase_q)) ? 7'h7F : seg[i];
      end
    end
  end

  always_ff @(posedge CLK_500Hz) begin
    if (!RESET_N) begin
      dig_q   <= {NUM_DIGITS{DIGIT_RESET}};
      last_q  <= LAST_B;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= HEX_OFF;
    end else begin
      dig_q   <= dig_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Scoreboard bench for hex_disp_ctrl with a behavioural digit/blink model.
module tb_hex_disp_ctrl;
  import hex_disp_pkg::*;

  localparam int unsigned BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, va, vb, lamp, ra, rb;
  logic [2:0] da, db;
  logic [1:0] oa, ob;
  logic [3:0] xa, xb;
  logic [7:0] h0, h1, h2, h3, h4, h5, h6, h7;
  logic [63:0] hex_all;
  assign hex_all = {h7, h6, h5, h4, h3, h2, h1, h0};

  hex_disp_ctrl #(.BLINK_DIV(BD), .CNT_W(16)) dut (
    .CLK_500Hz(clk), .RESET_N(rst_n),
    .req_a_valid(va), .req_a_ready(ra), .req_a_digit(da), .req_a_op(oa), .req_a_data(xa),
    .req_b_valid(vb), .req_b_ready(rb), .req_b_digit(db), .req_b_op(ob), .req_b_data(xb),
    .lamp_test(lamp),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5), .HEX6(h6), .HEX7(h7)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_val   [8];
  logic       m_blank [8];
  logic       m_blink [8];
  logic       m_dp    [8];
  int unsigned m_cnt;
  logic       m_phase, m_last_b;

  function automatic void model_reset();
    for (int d = 0; d < 8; d++) begin
      m_val[d] = 4'h0; m_blank[d] = 1'b1; m_blink[d] = 1'b0; m_dp[d] = 1'b0;
    end
    m_cnt = 0; m_phase = 1'b0; m_last_b = 1'b1;
  endfunction

  function automatic void model_cmd(logic [2:0] d, logic [1:0] op, logic [3:0] x);
    case (op)
      2'b00: begin m_val[d] = x; m_blank[d] = 1'b0; m_blink[d] = 1'b0; end
      2'b01: begin m_blank[d] = 1'b1; m_blink[d] = 1'b0; end
      2'b10: begin m_val[d] = x; m_blank[d] = 1'b0; m_blink[d] = 1'b1; end
      default: m_dp[d] = x[0];
    endcase
  endfunction

  function automatic logic [7:0] exp_hex(int d);
    if (!rst_n) return 8'hFF;
    if (lamp) return 8'h00;
    if (m_blank[d] || (m_blink[d] && m_phase)) return {~m_dp[d], 7'h7F};
    return {~m_dp[d], seg_tbl[m_val[d]]};
  endfunction

  function automatic void model_edge(logic ga, logic gb);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_cnt == BD - 1) begin m_cnt = 0; m_phase = !m_phase; end
    else m_cnt++;
    if (ga) begin model_cmd(da, oa, xa); m_last_b = 1'b0; end
    else if (gb) begin model_cmd(db, ob, xb); m_last_b = 1'b1; end
  endfunction

  // One clock: check readies before the edge, queue expected HEX, compare after.
  task automatic step(output logic obs_a, output logic obs_b);
    logic ga, gb;
    logic [63:0] e;
    #1;
    ga = rst_n && va && (!vb || m_last_b);
    gb = rst_n && vb && (!va || !m_last_b);
    obs_a = ra; obs_b = rb;
    total++;
    if (ra !== ga || rb !== gb) begin
      bad++;
      $display("FAIL ready t=%0t: got a=%b b=%b want a=%b b=%b", $time, ra, rb, ga, gb);
    end
    for (int d = 0; d < 8; d++) e[d*8 +: 8] = exp_hex(d);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(ga, gb);
    #1;
    e = exp_q.pop_front();
    total++;
    if (hex_all !== e) begin
      bad++;
      $display("FAIL hex t=%0t: got %h want %h", $time, hex_all, e);
    end
  endtask

  task automatic idle();
    va = 1'b0; vb = 1'b0;
  endtask

  task automatic do_reset();
    logic a, b;
    idle();
    rst_n = 1'b0;
    step(a, b);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic a, b;
    idle(); lamp = 1'b0; rst_n = 1'b0;
    va = 1'b1; da = 3'd0; oa = OP_SET; xa = 4'h9;
    for (int i = 0; i < 3; i++) begin
      step(a, b);
      total++;
      if (a !== 1'b0 || b !== 1'b0) begin
        bad++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", a, b);
      end
    end
    total++;
    if (hex_all !== {64{1'b1}} || dut.cnt_q !== 16'd0) begin
      bad++; $display("FAIL reset_state: hex=%h cnt=%0d want all FF cnt=0", hex_all, dut.cnt_q);
    end
    idle(); rst_n = 1'b1;
    step(a, b);
  endtask

  task automatic test_single_write();
    logic a, b;
    va = 1'b1; da = 3'd0; oa = OP_SET; xa = 4'h5;
    step(a, b);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", a); end
    idle();
    step(a, b);
    total++;
    if (h0 !== 8'h92 || hex_all[63:8] !== {56{1'b1}}) begin
      bad++; $display("FAIL single_hex: got %h want ffffffffffffff92", hex_all);
    end
  endtask

  task automatic test_arbitration();
    logic a, b;
    logic [3:0] sa, sb;
    do_reset();
    va = 1'b1; da = 3'd1; oa = OP_SET; xa = 4'h1;
    vb = 1'b1; db = 3'd2; ob = OP_SET; xb = 4'h2;
    for (int i = 0; i < 4; i++) begin
      step(a, b);
      sa[3-i] = a; sb[3-i] = b;
    end
    total++;
    if (sa !== 4'b1010 || sb !== 4'b0101) begin
      bad++; $display("FAIL arb_order: got a=%b b=%b want a=1010 b=0101", sa, sb);
    end
    va = 1'b0; xb = 4'hC;
    step(a, b);
    total++;
    if (b !== 1'b1) begin bad++; $display("FAIL arb_b_alone: got %b want 1", b); end
    va = 1'b1; xa = 4'hE;
    step(a, b);
    total++;
    if (a !== 1'b1 || b !== 1'b0) begin
      bad++; $display("FAIL arb_ptr: got a=%b b=%b want 1 0", a, b);
    end
    idle();
    step(a, b);
    total++;
    if (h1 !== 8'h86 || h2 !== 8'hC6) begin
      bad++; $display("FAIL arb_hex: got h1=%h h2=%h want 86 c6", h1, h2);
    end
  endtask

  task automatic test_blink();
    logic a, b;
    int n;
    do_reset();
    va = 1'b1; da = 3'd3; oa = OP_BLINK; xa = 4'h8;
    step(a, b);
    idle();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(a, b);
      if (h3 === 8'hFF) n++;
    end
    total++;
    if (n < 4 || n > 8) begin bad++; $display("FAIL blink_toggle: got off=%0d want 4..8", n); end
    n = 0;
    while (h3 !== 8'hFF && n < 10) begin step(a, b); n++; end
    total++;
    if (h3 !== 8'hFF) begin bad++; $display("FAIL blink_off_timeout: got %h want ff", h3); end
    rst_n = 1'b0;
    step(a, b);
    total++;
    if (h3 !== 8'hFF || dut.phase_q !== 1'b0 || dut.cnt_q !== 16'd0) begin
      bad++; $display("FAIL blink_reset: got h3=%h phase=%b cnt=%0d want ff 0 0", h3, dut.phase_q, dut.cnt_q);
    end
    rst_n = 1'b1;
    va = 1'b1; da = 3'd3; oa = OP_BLINK; xa = 4'h8;
    step(a, b);
    idle();
    step(a, b);
    total++;
    if (h3 !== 8'h80) begin bad++; $display("FAIL blink_phase0: got %h want 80", h3); end
    for (int i = 0; i < 6; i++) step(a, b);
  endtask

  task automatic test_dp_blank();
    logic a, b;
    va = 1'b1; da = 3'd7; oa = OP_SET; xa = 4'hA;
    step(a, b);
    oa = OP_DP; xa = 4'h1;
    step(a, b);
    idle();
    step(a, b);
    total++;
    if (h7 !== 8'h08) begin bad++; $display("FAIL dp_on: got %h want 08", h7); end
    va = 1'b1; oa = OP_BLANK; xa = 4'h0;
    step(a, b);
    idle();
    step(a, b);
    total++;
    if (h7 !== 8'h7F) begin bad++; $display("FAIL dp_blank: got %h want 7f", h7); end
  endtask

  task automatic test_lamp();
    logic a, b;
    lamp = 1'b1;
    va = 1'b1; da = 3'd4; oa = OP_SET; xa = 4'h3;
    step(a, b);
    total++;
    if (a !== 1'b1) begin bad++; $display("FAIL lamp_accept: got %b want 1", a); end
    idle();
    step(a, b);
    total++;
    if (hex_all !== 64'd0) begin bad++; $display("FAIL lamp_on: got %h want 0", hex_all); end
    lamp = 1'b0;
    step(a, b);
    total++;
    if (h4 !== 8'hB0 || h7 !== 8'h7F) begin
      bad++; $display("FAIL lamp_off: got h4=%h h7=%h want b0 7f", h4, h7);
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; lamp = 1'b0; va = 1'b0; vb = 1'b0;
    da = '0; db = '0; oa = '0; ob = '0; xa = '0; xb = '0;
    test_reset();
    test_single_write();
    test_arbitration();
    test_blink();
    test_dp_blank();
    test_lamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
